// File: rtl/vdma_rst_pkg.sv
// rtl/vdma_rst_pkg.sv - shared types and sizing helpers for the VDMA reset sequencer
package vdma_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } rst_state_e;

    // Counter must reach max(hold, step) - 1; never narrower than one bit.
    function automatic int cnt_width(input int hold_cycles, input int step_cycles);
        int m;
        m = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(input int num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

endpackage

// File: rtl/vdma_sync_nstage.sv
// rtl/vdma_sync_nstage.sv - one-bit N-stage synchroniser, async clear to 0 (asserted request)
module vdma_sync_nstage #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/vdma_rst_seq.sv
// rtl/vdma_rst_seq.sv - reset sequencer top; VDMA_RST_SEQ_SW_REQ_EN adds the software reset request/ack
module vdma_rst_seq
    import vdma_rst_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int NUM_OUT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic               sys_clk_i,
    input  logic               rstn_i,
    input  logic [NUM_SRC-1:0] rst_req_n_i,
`ifdef VDMA_RST_SEQ_SW_REQ_EN
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
`endif
    output logic [NUM_OUT-1:0] rstn_o,
    output logic               seq_done_o
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam int IDX_W = idx_width(NUM_OUT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    logic [NUM_SRC-1:0] req_sync;
    logic               src_ok;
    logic               done_rise;

    rst_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_OUT-1:0] rstn_q;
    logic               done_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        vdma_sync_nstage #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i  (sys_clk_i),
            .rstn_i (rstn_i),
            .d_i    (rst_req_n_i[g]),
            .q_o    (req_sync[g])
        );
    end

`ifdef VDMA_RST_SEQ_SW_REQ_EN
    assign src_ok = (&req_sync) & ~sw_rst_req_i;
`else
    assign src_ok = &req_sync;
`endif

    // Edge on which seq_done_o will rise; shared by the FSM and the software ack.
    assign done_rise = src_ok &&
        (((state_q == ST_HOLD) && (cnt_q == HOLD_LAST) && (NUM_OUT == 1)) ||
         ((state_q == ST_RELEASE) && (cnt_q == STEP_LAST) && (idx_q == IDX_LAST)));

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else if (!src_ok) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= '0;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rstn_q[0] <= 1'b1;
                        cnt_q     <= '0;
                        if (NUM_OUT == 1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= IDX_W'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        rstn_q <= rstn_q | (NUM_OUT'(1) << idx_q);
                        cnt_q  <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

`ifdef VDMA_RST_SEQ_SW_REQ_EN
    logic pend_q, pend_d;
    logic ack_q, ack_d;

    // Hardware requests leave the flag alone so the ack still follows the replay.
    always_comb begin
        pend_d = sw_rst_req_i | (pend_q & ~done_rise);
        ack_d  = done_rise & pend_q;
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    assign sw_rst_ack_o = ack_q;
`endif

    assign rstn_o     = rstn_q;
    assign seq_done_o = done_q;

endmodule
